// File: rtl/fft_sample_loader.sv
// Ping-pong frame loader for the FFT input memory; `FFT_LOADER_BITREV_EN stores frames in bit-reversed order.
// Latency: last write to frame_valid 1 cycle; rd_addr to rd_data 1 cycle (ROM-style registered read).
// Backpressure: s_ready drops while padding a short frame or while both banks await frame_done.
module fft_sample_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              frame_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_done,
    output logic              err_frame,
    input  logic              err_clr
);

    localparam int N = 1 << ADDR_W;

    typedef enum logic {
        FILL,
        PAD
    } wr_state_t;

    wr_state_t         state, state_nxt;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              accept;
    logic              at_end;
    logic              wr_en;
    logic [DATA_W-1:0] wr_dat;
    logic              close;
    logic              err_set;
    logic              release_bank;

    logic [DATA_W-1:0] mem [2*N];

    function automatic logic [ADDR_W-1:0] addr_map(input logic [ADDR_W-1:0] idx);
`ifdef FFT_LOADER_BITREV_EN
        logic [ADDR_W-1:0] rev;
        for (int b = 0; b < ADDR_W; b++) begin
            rev[b] = idx[ADDR_W-1-b];
        end
        return rev;
`else
        return idx;
`endif
    endfunction

    assign wr_addr      = addr_map(wr_cnt);
    assign at_end       = (wr_cnt == {ADDR_W{1'b1}});
    assign frame_valid  = full[rd_bank];
    assign release_bank = frame_done && full[rd_bank];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        accept    = 1'b0;
        wr_en     = 1'b0;
        wr_dat    = '0;
        close     = 1'b0;
        err_set   = 1'b0;
        case (state)
            FILL: begin
                s_ready = !full[wr_bank];
                accept  = s_valid && s_ready;
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_dat = s_data;
                    if (at_end) begin
                        close   = 1'b1;
                        err_set = !s_last;
                    end else if (s_last) begin
                        // short frame: zero-fill the remainder so the bank is always complete
                        err_set   = 1'b1;
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                wr_en = 1'b1;
                if (at_end) begin
                    close     = 1'b1;
                    state_nxt = FILL;
                end
            end
        endcase
    end

    // close and release never target the same bank: a bank being written is never full
    always_comb begin
        full_nxt = full;
        if (close) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (release_bank) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            err_frame <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
            full    <= full_nxt;
            if (wr_en) begin
                wr_cnt <= close ? '0 : wr_cnt + 1'b1;
            end
            if (close) begin
                wr_bank <= ~wr_bank;
            end
            if (release_bank) begin
                rd_bank <= ~rd_bank;
            end
            if (err_set) begin
                err_frame <= 1'b1;
            end else if (err_clr) begin
                err_frame <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_dat;
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader (N=8): directed table, corner-case sequences and random traffic
// compared every cycle against a frame-level reference model.
module tb_fft_sample_loader;

    localparam int AW = 3;
    localparam int N  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        frame_valid;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        frame_done = 1'b0;
    logic        err_frame;
    logic        err_clr = 1'b0;

    fft_sample_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .frame_valid(frame_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .err_frame  (err_frame),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: two frame buffers, a count of complete frames waiting, a pad flag
    logic [31:0] m_mem [2][N];
    bit          m_kn  [2][N];
    int          m_wr_b, m_rd_b, m_nfull, m_cnt;
    bit          m_pad, m_err;
    logic [31:0] m_rd;
    bit          m_rd_kn;

    // sample index stored at read address k
    int order [8];

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          l;
        logic [2:0]  ra;
        bit          fd;
        bit          e_rdy;
        bit          e_fv;
        bit          chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [18];

    function automatic int amap(int i);
`ifdef FFT_LOADER_BITREV_EN
        int r = 0;
        for (int b = 0; b < AW; b++) begin
            if (((i >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
        end
        return r;
`else
        return i;
`endif
    endfunction

    function automatic vec_t mk(bit v, logic [31:0] d, bit l, int ra, bit fd,
                                bit rdy, bit fv, bit cr, logic [31:0] erd);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.ra = 3'(ra); t.fd = fd;
        t.e_rdy = rdy; t.e_fv = fv; t.chk_rd = cr; t.e_rd = erd;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_pad && (m_nfull < 2);
    endfunction

    task automatic model_reset();
        m_wr_b = 0; m_rd_b = 0; m_nfull = 0; m_cnt = 0;
        m_pad = 0; m_err = 0; m_rd = '0; m_rd_kn = 1;
    endtask

    task automatic model_check();
        chkb("s_ready", s_ready, m_ready());
        chkb("frame_valid", frame_valid, m_nfull > 0);
        chkb("err_frame", err_frame, m_err);
        if (m_rd_kn) chk("rd_data", rd_data, m_rd);
    endtask

    task automatic model_step();
        bit acc, rel, close, set;
        int a;
        acc   = s_valid && m_ready();
        rel   = frame_done && (m_nfull > 0);
        close = 0;
        set   = 0;
        m_rd    = m_mem[m_rd_b][rd_addr];
        m_rd_kn = m_kn[m_rd_b][rd_addr];
        a = amap(m_cnt);
        if (m_pad) begin
            m_mem[m_wr_b][a] = '0;
            m_kn[m_wr_b][a]  = 1;
            if (m_cnt == N - 1) begin
                close = 1;
                m_pad = 0;
            end else m_cnt++;
        end else if (acc) begin
            m_mem[m_wr_b][a] = s_data;
            m_kn[m_wr_b][a]  = 1;
            if (m_cnt == N - 1) begin
                close = 1;
                set   = !s_last;
            end else begin
                if (s_last) begin
                    set   = 1;
                    m_pad = 1;
                end
                m_cnt++;
            end
        end
        if (close) begin
            m_cnt   = 0;
            m_wr_b ^= 1;
            m_nfull++;
        end
        if (rel) begin
            m_nfull--;
            m_rd_b ^= 1;
        end
        if (set) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    task automatic drive(bit v, logic [31:0] d, bit l, logic [2:0] ra, bit fd, bit ec);
        s_valid = v; s_data = d; s_last = l; rd_addr = ra; frame_done = fd; err_clr = ec;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic tick(bit v, logic [31:0] d, bit l, logic [2:0] ra, bit fd, bit ec);
        drive(v, d, l, ra, fd, ec);
        #1;
        model_check();
        advance();
    endtask

    initial begin
`ifdef FFT_LOADER_BITREV_EN
        order = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1, 32'h100 + i, i == 7, 0, 0, 1, 0, i == 0, 32'h0);
        tbl[8] = mk(0, 0, 0, 0, 0, 1, 1, 1, 32'(32'h100 + order[0]));
        for (int i = 9; i < 16; i++)
            tbl[i] = mk(0, 0, 0, i - 8, 0, 1, 1, 1, 32'(32'h100 + order[i - 9]));
        tbl[16] = mk(0, 0, 0, 0, 1, 1, 1, 1, 32'(32'h100 + order[7]));
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 0, 1, 32'(32'h100 + order[0]));

        // reset values
        #1;
        model_reset();
        chkb("rst_s_ready", s_ready, 1'b1);
        chkb("rst_frame_valid", frame_valid, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        chkb("rst_err_frame", err_frame, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // first frame, read back, release
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ra, tbl[i].fd, 1'b0);
            #1;
            model_check();
            chkb("tbl_ready", s_ready, tbl[i].e_rdy);
            chkb("tbl_fv", frame_valid, tbl[i].e_fv);
            chkb("tbl_err", err_frame, 1'b0);
            if (tbl[i].chk_rd) chk("tbl_rd", rd_data, tbl[i].e_rd);
            advance();
        end

        // back-pressure: two frames with no release
        for (int i = 0; i < 16; i++) tick(1, 32'h200 + i, (i % 8) == 7, 0, 0, 0);
        drive(1, 32'h2ff, 0, 0, 0, 0); #1; model_check();
        chkb("bp_ready_full", s_ready, 1'b0);
        advance();
        drive(1, 32'h2ff, 0, 0, 1, 0); #1; model_check();
        chkb("bp_ready_hold", s_ready, 1'b0);
        advance();
        drive(0, 0, 0, 0, 0, 0); #1; model_check();
        chkb("bp_ready_release", s_ready, 1'b1);
        chkb("bp_fv", frame_valid, 1'b1);
        advance();
        for (int a = 0; a < 9; a++) begin
            drive(0, 0, 0, 3'(a < 8 ? a : 0), 0, 0); #1; model_check();
            if (a > 0) chk("bp_second_frame", rd_data, 32'(32'h208 + order[a - 1]));
            advance();
        end
        tick(0, 0, 0, 0, 1, 0);

        // early s_last on index 4
        for (int i = 0; i < 5; i++) tick(1, 32'h300 + i, i == 4, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h3ff, 0, 0, 0, 0); #1; model_check();
            chkb("pad_ready", s_ready, 1'b0);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0); #1; model_check();
        chkb("pad_done_ready", s_ready, 1'b1);
        chkb("early_err", err_frame, 1'b1);
        chkb("early_fv", frame_valid, 1'b1);
        advance();
        for (int k = 5; k < 9; k++) begin
            drive(0, 0, 0, 3'(k < 8 ? amap(k) : 0), 0, 0); #1; model_check();
            if (k > 5) chk("pad_zero", rd_data, 32'h0);
            advance();
        end
        tick(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0); #1; model_check();
        chkb("err_clr", err_frame, 1'b0);
        advance();
        tick(0, 0, 0, 0, 1, 0);

        // missing s_last
        for (int i = 0; i < 8; i++) tick(1, 32'h400 + i, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); #1; model_check();
        chkb("miss_err", err_frame, 1'b1);
        chkb("miss_fv", frame_valid, 1'b1);
        advance();
        tick(0, 0, 0, 0, 1, 1);

        // reset mid-frame with a full bank pending
        for (int i = 0; i < 8; i++) tick(1, 32'h500 + i, i == 7, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 32'h5f0 + i, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        model_reset();
        chkb("midrst_fv", frame_valid, 1'b0);
        chkb("midrst_ready", s_ready, 1'b1);
        chk("midrst_rd", rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tick(1, 32'h600 + i, i == 7, 0, 0, 0);
        for (int a = 0; a < 9; a++) begin
            drive(0, 0, 0, 3'(a < 8 ? a : 0), 0, 0); #1; model_check();
            chkb("midrst_frame_fv", frame_valid, 1'b1);
            if (a > 0) chk("midrst_frame", rd_data, 32'(32'h600 + order[a - 1]));
            advance();
        end
        tick(0, 0, 0, 0, 1, 0);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
